// File: rtl/fixlat_pipe_sched.sv
// Round-robin issue scheduler for a fixed-latency, non-stallable datapath.
// Results return through a credit-protected show-ahead FIFO.
module fixlat_pipe_sched #(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 64,
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16,
  localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*DATA_W-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   pipe_valid_o,
  output logic [DATA_W-1:0]      pipe_data_o,
  input  logic [DATA_W-1:0]      pipe_res_i,
  output logic                   rsp_valid_o,
  output logic [DATA_W-1:0]      rsp_data_o,
  output logic [ID_W-1:0]        rsp_id_o,
  input  logic                   rsp_ready_i,
  output logic [CW-1:0]          credits_used_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [ID_W-1:0]   rr_ptr;
  logic [CW-1:0]     credits;
  logic              can_issue;
  logic              grant_any;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   idx;
  logic [DATA_W-1:0] grant_data;
  logic [ID_W-1:0]   pipe_id;

  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [LATENCY];

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]   mem_id   [FIFO_DEPTH];

  assign can_issue = credits < CW'(FIFO_DEPTH);

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && can_issue && !rst && req_valid_i[idx]) begin
        grant_any     = 1'b1;
        grant[idx]    = 1'b1;
        grant_id      = idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_data = req_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign req_ready_o = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_o <= 1'b0;
      pipe_data_o  <= '0;
    end else begin
      pipe_valid_o <= grant_any;
      if (grant_any) pipe_data_o <= grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_any) pipe_id <= grant_id;
  end

  // Only the valid bits are reset so in-flight results are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= pipe_valid_o;
      for (int k = 1; k < LATENCY; k++) tag_v[k] <= tag_v[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= pipe_id;
    for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
  end

  assign push  = tag_v[LATENCY-1];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rsp_valid_o = !empty;
  assign rsp_data_o  = mem_data[rd_ptr[AW-1:0]];
  assign rsp_id_o    = mem_id[rd_ptr[AW-1:0]];
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= pipe_res_i;
      mem_id[wr_ptr[AW-1:0]]   <= tag_id[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A credit is held from grant until its FIFO entry is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else begin
      unique case ({grant_any, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  assign credits_used_o = credits;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) push |-> !full
  );

endmodule

// File: tb/tb_fixlat_pipe_sched.sv
// Directed bench for fixlat_pipe_sched: two configurations,
// a datapath model that returns operand+1, and a response scoreboard.
module tb_fixlat_pipe_sched;

  localparam int DW = 16;
  localparam int L1 = 10;
  localparam int L2 = 1;

  typedef struct {
    logic [3:0] v;
    logic [3:0] g;
  } vec_t;

  typedef struct {
    int         id;
    logic [DW-1:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [3:0]    req_valid = '0;
  logic [4*DW-1:0] req_data = '0;
  logic [3:0]    req_ready;
  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic [DW-1:0] pipe_res;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_ready = 1'b0;
  logic [4:0]    credits;

  logic [0:0]    req_valid2 = '0;
  logic [DW-1:0] req_data2 = '0;
  logic [0:0]    req_ready2;
  logic          pipe_valid2;
  logic [DW-1:0] pipe_data2;
  logic [DW-1:0] pipe_res2;
  logic          rsp_valid2;
  logic [DW-1:0] rsp_data2;
  logic [0:0]    rsp_id2;
  logic          rsp_ready2 = 1'b0;
  logic [1:0]    credits2;

  logic [DW-1:0] dp1 [L1];
  logic [DW-1:0] dp2 [L2];

  exp_t q1[$];
  exp_t q2[$];
  vec_t tbl[9];
  logic [3:0]    pg = '0;
  logic [DW-1:0] pd = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixlat_pipe_sched #(
    .NREQ(4), .DATA_W(DW), .LATENCY(L1), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .pipe_valid_o(pipe_valid), .pipe_data_o(pipe_data),
    .pipe_res_i(pipe_res),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_id_o(rsp_id), .rsp_ready_i(rsp_ready),
    .credits_used_o(credits)
  );

  fixlat_pipe_sched #(
    .NREQ(1), .DATA_W(DW), .LATENCY(L2), .FIFO_DEPTH(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid2), .req_data_i(req_data2),
    .req_ready_o(req_ready2),
    .pipe_valid_o(pipe_valid2), .pipe_data_o(pipe_data2),
    .pipe_res_i(pipe_res2),
    .rsp_valid_o(rsp_valid2), .rsp_data_o(rsp_data2),
    .rsp_id_o(rsp_id2), .rsp_ready_i(rsp_ready2),
    .credits_used_o(credits2)
  );

  // Datapath models: result = operand + 1, LATENCY cycles later.
  always @(posedge clk) begin
    dp1[0] <= pipe_data;
    for (int k = 1; k < L1; k++) dp1[k] <= dp1[k-1];
    dp2[0] <= pipe_data2;
  end
  assign pipe_res  = dp1[L1-1] + 1'b1;
  assign pipe_res2 = dp2[L2-1] + 1'b1;

  task automatic chk(input bit ok, input string nm,
                     input longint a, input longint e);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic logic [4*DW-1:0] mk_data();
    logic [4*DW-1:0] d;
    for (int i = 0; i < 4; i++) d[i*DW +: DW] = DW'(cyc * 16 + i);
    return d;
  endfunction

  function automatic int oh(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic step(input logic [3:0] v, input logic rr,
                      input logic [3:0] g, input logic [4*DW-1:0] d,
                      input string nm);
    bit   ev;
    exp_t e;
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    @(negedge clk);
    chk(req_ready == g, {nm, "_ready"}, req_ready, g);
    chk(int'(credits) == q1.size(), {nm, "_credits"}, credits, q1.size());
    chk(pipe_valid == (pg != 0), {nm, "_pvalid"}, pipe_valid, pg != 0);
    if (pg != 0) chk(pipe_data == pd, {nm, "_pdata"}, pipe_data, pd);
    ev = (q1.size() > 0) && (q1[0].due <= cyc);
    chk(rsp_valid == ev, {nm, "_rvalid"}, rsp_valid, ev);
    if (ev) begin
      chk(rsp_data == q1[0].data, {nm, "_rdata"}, rsp_data, q1[0].data);
      chk(int'(rsp_id) == q1[0].id, {nm, "_rid"}, rsp_id, q1[0].id);
      if (rr) void'(q1.pop_front());
    end
    pg = g;
    if (g != 0) begin
      e.id   = oh(g);
      pd     = d[e.id*DW +: DW];
      e.data = pd + 1'b1;
      e.due  = cyc + L1 + 2;
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain1();
    for (int n = 0; n < 60 && q1.size() != 0; n++)
      step(4'h0, 1'b1, 4'h0, mk_data(), "drain");
    step(4'h0, 1'b1, 4'h0, mk_data(), "idle");
    chk(q1.size() == 0, "drain_timeout", q1.size(), 0);
  endtask

  task automatic step2(input logic g, input string nm);
    bit   ev;
    exp_t e;
    req_valid2 = 1'b1;
    req_data2  = DW'(cyc * 3 + 7);
    rsp_ready2 = 1'b1;
    @(negedge clk);
    chk(req_ready2 == g, {nm, "_ready"}, req_ready2, g);
    chk(int'(credits2) == q2.size(), {nm, "_credits"}, credits2, q2.size());
    ev = (q2.size() > 0) && (q2[0].due <= cyc);
    chk(rsp_valid2 == ev, {nm, "_rvalid"}, rsp_valid2, ev);
    if (ev) begin
      chk(rsp_data2 == q2[0].data, {nm, "_rdata"}, rsp_data2, q2[0].data);
      chk(rsp_id2 == 1'b0, {nm, "_rid"}, rsp_id2, 0);
      void'(q2.pop_front());
    end
    if (g) begin
      e.id   = 0;
      e.data = req_data2 + 1'b1;
      e.due  = cyc + L2 + 2;
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b0100, 4'b0100};
    tbl[2] = '{4'b0011, 4'b0001};
    tbl[3] = '{4'b1010, 4'b0010};
    tbl[4] = '{4'b1010, 4'b1000};
    tbl[5] = '{4'b1111, 4'b0001};
    tbl[6] = '{4'b1001, 4'b1000};
    tbl[7] = '{4'b1000, 4'b1000};
    tbl[8] = '{4'b0110, 4'b0010};

    rst        = 1'b1;
    req_valid  = 4'hF;
    req_valid2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(req_ready == 0, "rst_ready", req_ready, 0);
    chk(pipe_valid == 0, "rst_pvalid", pipe_valid, 0);
    chk(pipe_data == 0, "rst_pdata", pipe_data, 0);
    chk(rsp_valid == 0, "rst_rvalid", rsp_valid, 0);
    chk(credits == 0, "rst_credits", credits, 0);
    chk(req_ready2 == 0, "rst_ready2", req_ready2, 0);
    chk(credits2 == 0, "rst_credits2", credits2, 0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req_valid  = '0;
    req_valid2 = '0;

    for (int k = 0; k < 9; k++)
      step(tbl[k].v, 1'b1, tbl[k].g, mk_data(), "tbl");
    drain1();

    step(4'b0100, 1'b1, 4'b0100, 64'h0000_00A5_0000_0000, "single");
    drain1();

    for (int c = 0; c < 12; c++)
      step(4'hF, 1'b1, 4'(1 << ((3 + c) % 4)), mk_data(), "rr");
    drain1();

    for (int c = 0; c < 30; c++)
      step(4'h1, 1'b0, (c < 16) ? 4'h1 : 4'h0, mk_data(), "bp");
    step(4'h1, 1'b1, 4'h0, mk_data(), "bp_pop");
    step(4'h1, 1'b0, 4'h1, mk_data(), "bp_one");
    step(4'h1, 1'b0, 4'h0, mk_data(), "bp_hold");

    for (int c = 0; c < 6; c++)
      step(4'h1, 1'b1, (q1.size() < 16) ? 4'h1 : 4'h0, mk_data(), "pg15");
    for (int c = 0; c < 200; c++)
      step(4'h1, 1'($urandom_range(0, 1)),
           (q1.size() < 16) ? 4'h1 : 4'h0, mk_data(), "rand");
    drain1();

    for (int c = 0; c < 5; c++)
      step(4'h1, 1'b1, 4'h1, mk_data(), "mf_issue");
    repeat (3) step(4'h0, 1'b1, 4'h0, mk_data(), "mf_wait");
    rst       = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    chk(req_ready == 0, "mf_rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    chk(pipe_valid == 0, "mf_pvalid", pipe_valid, 0);
    chk(pipe_data == 0, "mf_pdata", pipe_data, 0);
    chk(rsp_valid == 0, "mf_rvalid", rsp_valid, 0);
    chk(credits == 0, "mf_credits", credits, 0);
    q1.delete();
    pg = '0;
    repeat (16) step(4'h0, 1'b1, 4'h0, mk_data(), "mf_stale");
    step(4'b0011, 1'b1, 4'b0001, mk_data(), "mf_new");
    drain1();

    for (int c = 0; c < 16; c++)
      step2((c % 4) < 2, "thr");
    for (int n = 0; n < 10; n++) begin
      req_valid2 = 1'b0;
      @(negedge clk);
      if (q2.size() > 0 && q2[0].due <= cyc) begin
        chk(rsp_valid2 == 1'b1, "thr_drain_rvalid", rsp_valid2, 1);
        chk(rsp_data2 == q2[0].data, "thr_drain_rdata",
            rsp_data2, q2[0].data);
        void'(q2.pop_front());
      end
      @(posedge clk);
      #1;
    end
    chk(q2.size() == 0, "thr_lost", q2.size(), 0);
    chk(rsp_valid2 == 1'b0, "thr_empty", rsp_valid2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
